// File: rtl/iiitb_cg_ctrl_if.sv
// rtl/iiitb_cg_ctrl_if.sv - activity/handshake bundle between gated domain, consumer and clock-gate controller
interface iiitb_cg_ctrl_if;
    logic        act;
    logic        force_on;
    logic        sleep_ack;
    logic        gate_en;
    logic        sleep_req;
    logic        ready;
    logic [2:0]  state;
    logic [15:0] gated_cycles;

    // Environment side: reports activity, acknowledges sleep, observes gating status
    modport master (
        output act,
        output force_on,
        output sleep_ack,
        input  gate_en,
        input  sleep_req,
        input  ready,
        input  state,
        input  gated_cycles
    );

    // Controller side
    modport slave (
        input  act,
        input  force_on,
        input  sleep_ack,
        output gate_en,
        output sleep_req,
        output ready,
        output state,
        output gated_cycles
    );
endinterface

// File: rtl/iiitb_cg_ctrl.sv
// rtl/iiitb_cg_ctrl.sv - idle-driven clock-gate controller with sleep handshake and gated-cycle counter
module iiitb_cg_ctrl #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    iiitb_cg_ctrl_if.slave cg
);

    localparam logic [2:0] ST_ON    = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_OFF   = 3'd3;
    localparam logic [2:0] ST_WAKE  = 3'd4;

    localparam logic [7:0]  IDLE_LIM = 8'(IDLE_CYCLES);
    localparam logic [3:0]  WAKE_LIM = 4'(WAKE_CYCLES);
    localparam logic [15:0] GATED_MAX = 16'hFFFF;

    logic [2:0]  state_q, state_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic [3:0]  wake_cnt_q, wake_cnt_d;
    logic [15:0] gated_q, gated_d;
    logic        wake;

    // force_on is folded into activity so it can never let the domain be gated
    assign wake = cg.act | cg.force_on;

    // Next-state and counter update; sleep_ack only matters while a request is outstanding
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_ON: begin
                if (!wake) begin
                    state_d    = ST_COUNT;
                    idle_cnt_d = 8'd1;
                end
            end
            ST_COUNT: begin
                if (wake) begin
                    state_d    = ST_ON;
                    idle_cnt_d = 8'd0;
                end else if (idle_cnt_q == IDLE_LIM) begin
                    state_d = ST_REQ;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            ST_REQ: begin
                // activity aborts the request even if the ack arrives in the same cycle
                if (wake) begin
                    state_d    = ST_ON;
                    idle_cnt_d = 8'd0;
                end else if (cg.sleep_ack) begin
                    state_d = ST_OFF;
                end
            end
            ST_OFF: begin
                if (wake) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = 4'd1;
                end
            end
            ST_WAKE: begin
                // clock already running; hold ready low until the domain has settled
                if (wake_cnt_q == WAKE_LIM) begin
                    state_d    = ST_ON;
                    wake_cnt_d = 4'd0;
                    idle_cnt_d = 8'd0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = ST_ON;
                idle_cnt_d = 8'd0;
                wake_cnt_d = 4'd0;
            end
        endcase
    end

    // Count cycles spent gated, saturating rather than wrapping
    always_comb begin
        gated_d = gated_q;
        if (state_q == ST_OFF && gated_q != GATED_MAX) begin
            gated_d = gated_q + 16'd1;
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ON;
            idle_cnt_q <= 8'd0;
            wake_cnt_q <= 4'd0;
            gated_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            gated_q    <= gated_d;
        end
    end

    // Moore output decode from registered state only
    always_comb begin
        cg.gate_en   = 1'b1;
        cg.ready     = 1'b0;
        cg.sleep_req = 1'b0;
        case (state_q)
            ST_ON, ST_COUNT: begin
                cg.ready = 1'b1;
            end
            ST_REQ: begin
                cg.ready     = 1'b1;
                cg.sleep_req = 1'b1;
            end
            ST_OFF: begin
                cg.gate_en   = 1'b0;
                cg.sleep_req = 1'b1;
            end
            default: begin
                cg.gate_en = 1'b1;
            end
        endcase
    end

    assign cg.state        = state_q;
    assign cg.gated_cycles = gated_q;

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// tb/tb_iiitb_cg_ctrl.sv - self-checking bench for iiitb_cg_ctrl against a phase-level reference model
module tb_iiitb_cg_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    iiitb_cg_ctrl_if if0 ();
    iiitb_cg_ctrl_if if1 ();

    iiitb_cg_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .cg  (if0.slave)
    );

    iiitb_cg_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .cg  (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {P_AWAKE, P_REQ, P_OFF, P_WAKE} phase_t;

    phase_t m_ph    [2];
    int     m_idle  [2];
    int     m_wk    [2];
    int     m_gated [2];
    int     lim_idle[2] = '{4, 1};
    int     lim_wake[2] = '{2, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: "awake" covers ON and COUNT, distinguished only by the running idle count
    task automatic model_step(input int k, input bit a, input bit f, input bit s, input bit r);
        bit w;
        w = a | f;
        if (r) begin
            m_ph[k] = P_AWAKE; m_idle[k] = 0; m_wk[k] = 0; m_gated[k] = 0;
            return;
        end
        case (m_ph[k])
            P_AWAKE: begin
                if (w) m_idle[k] = 0;
                else if (m_idle[k] == lim_idle[k]) begin m_ph[k] = P_REQ; m_idle[k] = 0; end
                else m_idle[k]++;
            end
            P_REQ: begin
                if (w) m_ph[k] = P_AWAKE;
                else if (s) m_ph[k] = P_OFF;
            end
            P_OFF: begin
                if (m_gated[k] < 65535) m_gated[k]++;
                if (w) begin m_ph[k] = P_WAKE; m_wk[k] = 1; end
            end
            P_WAKE: begin
                if (m_wk[k] == lim_wake[k]) begin m_ph[k] = P_AWAKE; m_idle[k] = 0; end
                else m_wk[k]++;
            end
        endcase
    endtask

    function automatic logic [31:0] exp_state(input int k);
        case (m_ph[k])
            P_AWAKE: return (m_idle[k] == 0) ? 32'd0 : 32'd1;
            P_REQ:   return 32'd2;
            P_OFF:   return 32'd3;
            default: return 32'd4;
        endcase
    endfunction

    task automatic compare_all();
        check("d0_state", {29'd0, if0.state}, exp_state(0));
        check("d0_gate_en", {31'd0, if0.gate_en}, {31'd0, m_ph[0] != P_OFF});
        check("d0_ready", {31'd0, if0.ready}, {31'd0, m_ph[0] == P_AWAKE || m_ph[0] == P_REQ});
        check("d0_sleep_req", {31'd0, if0.sleep_req}, {31'd0, m_ph[0] == P_REQ || m_ph[0] == P_OFF});
        check("d0_gated", {16'd0, if0.gated_cycles}, m_gated[0]);
        check("d1_state", {29'd0, if1.state}, exp_state(1));
        check("d1_gate_en", {31'd0, if1.gate_en}, {31'd0, m_ph[1] != P_OFF});
        check("d1_ready", {31'd0, if1.ready}, {31'd0, m_ph[1] == P_AWAKE || m_ph[1] == P_REQ});
        check("d1_sleep_req", {31'd0, if1.sleep_req}, {31'd0, m_ph[1] == P_REQ || m_ph[1] == P_OFF});
        check("d1_gated", {16'd0, if1.gated_cycles}, m_gated[1]);
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, sample on the next falling edge
    task automatic cycle(input bit a, input bit f, input bit s, input bit r);
        if0.act = a; if0.force_on = f; if0.sleep_ack = s;
        if1.act = a; if1.force_on = f; if1.sleep_ack = s;
        rst = r;
        @(posedge clk);
        model_step(0, a, f, s, r);
        model_step(1, a, f, s, r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        bit flag;
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = P_AWAKE; m_idle[k] = 0; m_wk[k] = 0; m_gated[k] = 0;
        end
        @(negedge clk);

        // reset for two cycles
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("rst_state", {29'd0, if0.state}, 32'd0);
        check("rst_gate_ready", {30'd0, if0.gate_en, if0.ready}, 32'd3);

        // idle from reset with ack held: COUNT, REQ, OFF timing
        for (int e = 1; e <= 6; e++) begin
            cycle(0, 0, 1, 0);
            if (e == 1) check("idle_count_e1", {29'd0, if0.state}, 32'd1);
            if (e == 5) check("idle_req_e5", {29'd0, if0.state}, 32'd2);
            if (e == 6) check("idle_off_e6", {30'd0, if0.state[1:0] == 2'd3, if0.gate_en}, 32'd2);
        end

        // ten OFF cycles, the last one sampling activity; then wake latency
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 0);
        check("wake_gated10", {16'd0, if0.gated_cycles}, 32'd10);
        check("wake_gate_en", {31'd0, if0.gate_en}, 32'd1);
        check("wake_ready0", {31'd0, if0.ready}, 32'd0);
        cycle(0, 0, 1, 0);
        check("wake_state_mid", {29'd0, if0.state}, 32'd4);
        cycle(0, 0, 1, 0);
        check("wake_ready1", {28'd0, if0.ready, if0.state}, 32'h8);

        // abort in REQ: activity and ack together
        cycle(0, 0, 0, 1);
        flag = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0);
            if (!if0.gate_en) flag = 1;
        end
        check("abort_in_req", {29'd0, if0.state}, 32'd2);
        cycle(1, 0, 1, 0);
        if (!if0.gate_en) flag = 1;
        check("abort_state_on", {29'd0, if0.state}, 32'd0);
        check("abort_sleep_req", {31'd0, if0.sleep_req}, 32'd0);
        check("abort_gate_never_low", {31'd0, flag}, 32'd0);
        cycle(1, 0, 1, 0);
        check("ack_ignored_in_on", {29'd0, if0.state}, 32'd0);

        // activity toggling every 3 cycles never reaches REQ
        cycle(0, 0, 0, 1);
        flag = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(((i / 3) % 2) == 0, 0, 0, 0);
            if (if0.sleep_req || if0.state == 3'd2) flag = 1;
        end
        check("toggle_no_req", {31'd0, flag}, 32'd0);

        // force_on holds the domain on
        cycle(0, 0, 0, 1);
        flag = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(0, 1, $urandom_range(0, 1), 0);
            if (if0.state != 3'd0 || !if0.gate_en) flag = 1;
        end
        check("force_on_hold", {31'd0, flag}, 32'd0);

        // reset in OFF after 7 gated cycles
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0);
        check("off_gated7", {16'd0, if0.gated_cycles}, 32'd7);
        cycle(0, 0, 1, 1);
        check("rst_off_state", {29'd0, if0.state}, 32'd0);
        check("rst_off_gate_en", {31'd0, if0.gate_en}, 32'd1);
        check("rst_off_gated0", {16'd0, if0.gated_cycles}, 32'd0);

        // saturation of the gated-cycle counter
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);
        for (int i = 0; i < 70000; i++) cycle(0, 0, 1, 0);
        check("gated_saturate", {16'd0, if0.gated_cycles}, 32'hFFFF);
        cycle(1, 0, 0, 0);
        check("gated_no_wrap", {16'd0, if0.gated_cycles}, 32'hFFFF);

        // randomized traffic with sparse activity and occasional reset
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iiitb_cg_ctrl.md
IIITB_CG_CTRL -- requirements
Module: iiitb_cg_ctrl

Interface
REQ-001 Parameter: IDLE_CYCLES, default 8, consecutive idle cycles before a sleep request; legal range 1..255.
REQ-002 Parameter: WAKE_CYCLES, default 2, cycles spent in WAKE before ready; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port: rst  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 Port: act  input  1  activity indication from the gated domain; 1 = busy.
REQ-006 Port: force_on  input  1  1 = never gate; treated as activity.
REQ-007 Port: sleep_ack  input  1  consumer acknowledge of sleep_req.
REQ-008 Port: gate_en  output  1  enable to the integrated clock gate; 1 = clock runs.
REQ-009 Port: sleep_req  output  1  request to the consumer to gate the clock.
REQ-010 Port: ready  output  1  1 = gated domain is clocked and usable.
REQ-011 Port: state  output  3  current FSM encoding: ON=0, COUNT=1, REQ=2, OFF=3, WAKE=4.
REQ-012 Port: gated_cycles  output  16  count of cycles spent in OFF.

Function
REQ-013 Moore FSM; all outputs decode from registered state and counters, with no combinational input-to-output path.
REQ-014 wake = act | force_on; wake is evaluated every cycle.
REQ-015 ON: gate_en=1, ready=1, sleep_req=0; if !wake -> COUNT with idle_cnt=1; else stay.
REQ-016 COUNT: gate_en=1, ready=1, sleep_req=0; if wake -> ON and idle_cnt=0; else if idle_cnt==IDLE_CYCLES -> REQ; else idle_cnt+1.
REQ-017 IDLE_CYCLES==1: ON -> COUNT -> REQ on consecutive idle cycles (minimum two idle cycles ON-to-REQ).
REQ-018 REQ: gate_en=1, ready=1, sleep_req=1; if wake -> ON (abort; sleep_req drops next cycle); else if sleep_ack -> OFF; else stay.
REQ-019 wake and sleep_ack high in the same REQ cycle -> ON; wake has priority.
REQ-020 OFF: gate_en=0, ready=0, sleep_req=1; gated_cycles+1 per OFF cycle, saturating at 0xFFFF; if wake -> WAKE with wake_cnt=1.
REQ-021 WAKE: gate_en=1, ready=0, sleep_req=0; if wake_cnt==WAKE_CYCLES -> ON; else wake_cnt+1; act/sleep_ack ignored.
REQ-022 Latency: wake sampled high in OFF at edge n -> gate_en=1 after edge n; ready=1 after edge n+WAKE_CYCLES.
REQ-023 sleep_ack outside REQ is ignored; no state change.
REQ-024 gated_cycles never wraps and is cleared only by rst.
REQ-025 Illegal state encodings (5..7) -> ON on next edge.

Reset
REQ-026 rst=1 at posedge clk -> state=ON, gate_en=1, ready=1, sleep_req=0, idle_cnt=0, wake_cnt=0, gated_cycles=0.
REQ-027 rst has priority over all inputs in every state, including mid-handshake in REQ and mid-WAKE.
REQ-028 Power-up without rst is undefined; bench shall apply rst for at least 2 cycles.

Verification
REQ-029 Test: IDLE_CYCLES=4, act=0 from reset, sleep_ack=1 -> COUNT after 1 edge, REQ after 5 edges, OFF after 6 edges with gate_en=0.
REQ-030 Test: In OFF 10 cycles, then act=1 for 1 cycle (WAKE_CYCLES=2) -> gated_cycles=10, gate_en=1 next cycle, ready=1 two cycles later, state=ON.
REQ-031 Test: In REQ, act=1 and sleep_ack=1 same cycle -> state=ON, sleep_req=0, gate_en never 0.
REQ-032 Test: act toggles 1/0 every 3 cycles with IDLE_CYCLES=4 -> never reaches REQ; sleep_req stays 0.
REQ-033 Test: force_on=1, act=0 for 100 cycles -> state=ON throughout, gate_en=1.
REQ-034 Test: rst=1 during OFF with gated_cycles=7 -> next cycle state=ON, gate_en=1, gated_cycles=0; saturation check: 70000 OFF cycles -> gated_cycles=0xFFFF.
